// File: rtl/if_stage_if.sv
// Instruction ROM bus between the fetch stage and the instruction ROM.
// The fetch stage (master) drives the chip enable and the fetch address.
// The ROM (slave) returns the instruction combinationally. It returns zero
// while the chip enable is low.
interface if_stage_if;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;

    modport master (
        output rom_ce,
        output rom_addr,
        input  rom_inst
    );

    modport slave (
        input  rom_ce,
        input  rom_addr,
        output rom_inst
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage.
// - Owns the program counter and drives the instruction ROM.
// - Registers the fetched word into the IF/ID latch.
// - Applies flush, stall and branch redirects.
// - Parks a branch that arrives while fetch is stalled, so it is not lost.
//
// Optional feature: define IF_ALIGN_CHECK_EN to flag misaligned fetches on
// id_exc_adel. A flagged fetch latches a bubble word. When the macro is
// undefined, id_exc_adel is tied low.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_if,
    input  logic               stall_id,
    input  logic               flush,
    input  logic [31:0]        new_pc,
    input  logic               branch_flag_i,
    input  logic [31:0]        branch_target_i,
    if_stage_if.master         rom,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_inst,
    output logic               id_exc_adel
);

    logic        ce_q;
    logic [31:0] pc_q,          pc_d;
    logic        pend_valid_q,  pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] id_pc_q,       id_pc_d;
    logic [31:0] id_inst_q,     id_inst_d;
    logic        id_adel_q,     id_adel_d;
    logic        misalign;

`ifdef IF_ALIGN_CHECK_EN
    assign misalign = ce_q & (pc_q[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Next PC and pending-branch state.
    // Priority: flush, then stall, then the parked branch, then a live
    // branch, then sequential fetch. The PC holds RESET_PC until the ROM
    // is enabled.
    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (ce_q) begin
            if (flush) begin
                pc_d         = new_pc;
                pend_valid_d = 1'b0;
            end else if (stall_if) begin
                // Park only the first branch seen during a stall. Execute
                // cannot issue a second branch across the same stall.
                if (branch_flag_i && !pend_valid_q) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = branch_target_i;
                end
            end else if (pend_valid_q) begin
                pc_d         = pend_target_q;
                pend_valid_d = 1'b0;
            end else if (branch_flag_i) begin
                pc_d = branch_target_i;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    // Next IF/ID latch contents.
    // A redirect cycle still captures the current pair; only flush drops it.
    always_comb begin
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;
        id_adel_d = id_adel_q;
        if (flush) begin
            id_pc_d   = 32'h0;
            id_inst_d = 32'h0;
            id_adel_d = 1'b0;
        end else if (stall_if && !stall_id) begin
            id_pc_d   = 32'h0;
            id_inst_d = 32'h0;
            id_adel_d = 1'b0;
        end else if (!stall_id) begin
            id_pc_d   = pc_q;
            id_inst_d = misalign ? 32'h0 : rom.rom_inst;
            id_adel_d = misalign;
        end
    end

    // Fetch-side state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_q          <= 1'b0;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            ce_q          <= 1'b1;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    // IF/ID pipeline latch with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pc_q   <= 32'h0;
            id_inst_q <= 32'h0;
            id_adel_q <= 1'b0;
        end else begin
            id_pc_q   <= id_pc_d;
            id_inst_q <= id_inst_d;
            id_adel_q <= id_adel_d;
        end
    end

    assign rom.rom_ce   = ce_q;
    assign rom.rom_addr = pc_q;
    assign id_pc        = id_pc_q;
    assign id_inst      = id_inst_q;
    assign id_exc_adel  = id_adel_q;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: a table of per-cycle vectors plus an async-reset
// sequence. A ROM model returns a distinct, address-derived word.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_if, stall_id, flush, branch_flag_i;
    logic [31:0] new_pc, branch_target_i;
    logic [31:0] id_pc, id_inst;
    logic        id_exc_adel;

    int checks = 0;
    int errors = 0;

`ifdef IF_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    if_stage_if rom_bus ();

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .flush           (flush),
        .new_pc          (new_pc),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom             (rom_bus.master),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .id_exc_adel     (id_exc_adel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    assign rom_bus.rom_inst = rom_bus.rom_ce ? w(rom_bus.rom_addr) : 32'h0;

    typedef struct {
        logic        sif, sid, fl;
        logic [31:0] npc;
        logic        br;
        logic [31:0] bt;
        logic [31:0] e_addr, e_pc, e_inst;
        logic        e_adel;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] addr, pc, inst;
        logic        adel;
    } exp_t;

    vec_t vecs[27];
    exp_t sb[$];

    function automatic vec_t mk(logic sif, logic sid, logic fl, logic [31:0] npc,
                                logic br, logic [31:0] bt, logic [31:0] ea,
                                logic [31:0] ep, logic [31:0] ei, logic eadel);
        vec_t v;
        v.sif = sif; v.sid = sid; v.fl = fl; v.npc = npc; v.br = br; v.bt = bt;
        v.e_addr = ea; v.e_pc = ep; v.e_inst = ei; v.e_adel = eadel;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sif, input logic sid, input logic fl,
                         input logic [31:0] npc, input logic br, input logic [31:0] bt);
        stall_if = sif; stall_id = sid; flush = fl; new_pc = npc;
        branch_flag_i = br; branch_target_i = bt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got 0 want 1");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] i102, i106;
        exp_t e;
        i102 = ALIGN ? 32'h0 : w(32'h102);
        i106 = ALIGN ? 32'h0 : w(32'h106);

        //             sif  sid  fl   npc            br   bt             addr           id_pc          id_inst            adel
        vecs[0]  = mk(0, 0, 0, 32'h0,         0, 32'h0,   32'h0,         32'h0,         32'h0,             0);
        vecs[1]  = mk(0, 0, 0, 32'h0,         0, 32'h0,   32'h4,         32'h0,         w(32'h0),          0);
        vecs[2]  = mk(0, 0, 0, 32'h0,         0, 32'h0,   32'h8,         32'h4,         w(32'h4),          0);
        vecs[3]  = mk(0, 0, 0, 32'h0,         1, 32'h40,  32'h40,        32'h8,         w(32'h8),          0);
        vecs[4]  = mk(0, 0, 0, 32'h0,         0, 32'h0,   32'h44,        32'h40,        w(32'h40),         0);
        vecs[5]  = mk(1, 0, 0, 32'h0,         1, 32'h100, 32'h44,        32'h0,         32'h0,             0);
        vecs[6]  = mk(1, 0, 0, 32'h0,         0, 32'h0,   32'h44,        32'h0,         32'h0,             0);
        vecs[7]  = mk(0, 0, 0, 32'h0,         0, 32'h0,   32'h100,       32'h44,        w(32'h44),         0);
        vecs[8]  = mk(0, 0, 0, 32'h0,         0, 32'h0,   32'h104,       32'h100,       w(32'h100),        0);
        vecs[9]  = mk(0, 1, 0, 32'h0,         0, 32'h0,   32'h108,       32'h100,       w(32'h100),        0);
        vecs[10] = mk(1, 1, 0, 32'h0,         0, 32'h0,   32'h108,       32'h100,       w(32'h100),        0);
        vecs[11] = mk(1, 0, 0, 32'h0,         1, 32'h200, 32'h108,       32'h0,         32'h0,             0);
        vecs[12] = mk(1, 0, 1, 32'h380,       1, 32'h300, 32'h380,       32'h0,         32'h0,             0);
        vecs[13] = mk(0, 0, 0, 32'h0,         0, 32'h0,   32'h384,       32'h380,       w(32'h380),        0);
        vecs[14] = mk(0, 0, 1, 32'hFFFF_FFF8, 0, 32'h0,   32'hFFFF_FFF8, 32'h0,         32'h0,             0);
        vecs[15] = mk(0, 0, 0, 32'h0,         0, 32'h0,   32'hFFFF_FFFC, 32'hFFFF_FFF8, w(32'hFFFF_FFF8),  0);
        vecs[16] = mk(0, 0, 0, 32'h0,         0, 32'h0,   32'h0,         32'hFFFF_FFFC, w(32'hFFFF_FFFC),  0);
        vecs[17] = mk(0, 0, 0, 32'h0,         0, 32'h0,   32'h4,         32'h0,         w(32'h0),          0);
        vecs[18] = mk(0, 0, 1, 32'h102,       0, 32'h0,   32'h102,       32'h0,         32'h0,             0);
        vecs[19] = mk(0, 0, 0, 32'h0,         0, 32'h0,   32'h106,       32'h102,       i102,              ALIGN);
        vecs[20] = mk(0, 0, 0, 32'h0,         0, 32'h0,   32'h10A,       32'h106,       i106,              ALIGN);
        vecs[21] = mk(0, 0, 1, 32'h200,       0, 32'h0,   32'h200,       32'h0,         32'h0,             0);
        vecs[22] = mk(1, 0, 0, 32'h0,         1, 32'h300, 32'h200,       32'h0,         32'h0,             0);
        vecs[23] = mk(0, 0, 0, 32'h0,         1, 32'h500, 32'h300,       32'h200,       w(32'h200),        0);
        vecs[24] = mk(0, 0, 0, 32'h0,         0, 32'h0,   32'h304,       32'h300,       w(32'h300),        0);
        vecs[25] = mk(0, 1, 1, 32'h10,        0, 32'h0,   32'h10,        32'h0,         32'h0,             0);
        vecs[26] = mk(0, 0, 0, 32'h0,         0, 32'h0,   32'h14,        32'h10,        w(32'h10),         0);

        // Reset state.
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset rom_ce",  {31'h0, rom_bus.rom_ce}, 32'h0);
        chk("reset rom_addr", rom_bus.rom_addr, 32'h0);
        chk("reset id_pc",    id_pc, 32'h0);
        chk("reset id_inst",  id_inst, 32'h0);
        chk("reset id_adel", {31'h0, id_exc_adel}, 32'h0);

        // Table-driven vectors through a scoreboard queue.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].sif, vecs[i].sid, vecs[i].fl, vecs[i].npc, vecs[i].br, vecs[i].bt);
            e.idx = i; e.addr = vecs[i].e_addr; e.pc = vecs[i].e_pc;
            e.inst = vecs[i].e_inst; e.adel = vecs[i].e_adel;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard empty got 0 want 1");
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d rom_ce", e.idx), {31'h0, rom_bus.rom_ce}, 32'h1);
                chk($sformatf("v%0d rom_addr", e.idx), rom_bus.rom_addr, e.addr);
                chk($sformatf("v%0d id_pc", e.idx), id_pc, e.pc);
                chk($sformatf("v%0d id_inst", e.idx), id_inst, e.inst);
                chk($sformatf("v%0d id_adel", e.idx), {31'h0, id_exc_adel}, {31'h0, e.adel});
            end
            @(negedge clk);
        end

        // Async reset mid-operation, with a parked branch outstanding.
        drive(1, 0, 0, 32'h0, 1, 32'h700);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        rst = 1'b1;
        #1;
        chk("async rom_ce",  {31'h0, rom_bus.rom_ce}, 32'h0);
        chk("async rom_addr", rom_bus.rom_addr, 32'h0);
        chk("async id_pc",    id_pc, 32'h0);
        chk("async id_inst",  id_inst, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset rom_ce", {31'h0, rom_bus.rom_ce}, 32'h1);
        chk("post-reset addr0",  rom_bus.rom_addr, 32'h0);
        chk("post-reset bubble", id_inst, 32'h0);
        @(posedge clk);
        #1;
        chk("post-reset addr1",  rom_bus.rom_addr, 32'h4);
        chk("post-reset inst1",  id_inst, w(32'h0));
        chk("post-reset pc1",    id_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
